pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the program counter (PC) and sequences instruction fetch.
- Applies redirects resolved by the branch/jump unit and inserts a fixed-length pipeline flush after each taken redirect.
- Halts on a misaligned redirect target.
- Sits between the branch/jump resolver, the instruction-memory port and the fetch/decode pipeline registers.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, cycles flush is held after a taken redirect; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- stall  in  1  pipeline stall; blocks issue of a new fetch.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  XLEN  fetch address; always equals pc.
- imem_ack  in  1  instruction memory accepted/returned the outstanding fetch.
- redir_valid  in  1  branch/jump unit has a resolved result this cycle.
- redir_taken  in  1  the resolved branch/jump is taken; qualified by redir_valid.
- redir_target  in  XLEN  redirect address; qualified by redir_valid and redir_taken.
- flush  out  1  kill younger instructions in fetch/decode.
- pc  out  XLEN  current PC.
- misalign_err  out  1  sticky error: a taken target had target[1:0] != 0.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: pc = RESET_VECTOR, state = BOOT, imem_req = 0, flush = 0, misalign_err = 0, flush counter = 0, outstanding = 0.
- States: BOOT, FETCH, FLUSH, HALT.
- BOOT:
  - Lasts exactly 1 cycle after rst_n deasserts, then goes to FETCH.
  - Redirects are ignored in BOOT.
- FETCH:
  - imem_req = outstanding OR !stall.
  - A request, once asserted, stays high with imem_addr stable until imem_ack, regardless of stall. outstanding is set while req=1 and ack=0.
  - imem_ack with req=1: pc <= pc + 4 (mod 2^XLEN, wrap with no error) and outstanding clears.
  - Fetch latency is 0 or more cycles; an ack with req=0 is ignored.
- Taken redirect (redir_valid & redir_taken) in FETCH or FLUSH:
  - If redir_target[1:0] == 0: pc <= redir_target, outstanding clears (any in-flight fetch is abandoned), the counter is loaded with FLUSH_CYCLES, and the block enters FLUSH.
  - If redir_target[1:0] != 0: misalign_err <= 1, pc is unchanged, and the block enters HALT.
  - A redirect takes priority over a same-cycle imem_ack: pc gets the target, not pc+4.
- Not-taken results, or redir_valid with redir_taken = 0: no effect.
- FLUSH:
  - flush = 1 and imem_req = 0.
  - The counter decrements each cycle; when it reaches 1, the next state is FETCH.
  - flush is therefore high for exactly FLUSH_CYCLES consecutive cycles.
  - A new taken redirect during FLUSH reloads the counter and pc; the flush window restarts from that cycle.
  - stall has no effect in FLUSH.
- HALT:
  - imem_req = 0, flush = 1 held, pc frozen.
  - All inputs are ignored. The only exit is rst_n.
- flush and imem_req are registered/state-decoded outputs, with no combinational path from redir_* to any output.
- Reset asserted mid-transaction or mid-flush returns the block to reset values immediately (asynchronous). No pending state survives.

Test Plan:
- Release reset, stall = 0, ack every cycle:
  - imem_req rises 1 cycle after BOOT.
  - imem_addr sequence is 0x0, 0x4, 0x8, 0xC.
- Ack delayed 3 cycles with stall asserted mid-wait:
  - imem_req stays high and imem_addr stays 0x4 until ack, then advances to 0x8.
  - After that, no request is issued while stall = 1.
- Taken redirect to 0x100 in the same cycle as ack at pc = 0x8:
  - pc = 0x100 (not 0xC).
  - flush is high 2 cycles with imem_req = 0.
  - Fetch resumes at 0x100.
- Second taken redirect to 0x200 on the 2nd flush cycle:
  - flush stays high 2 more cycles (3 total).
  - The next fetch is at 0x200.
- Taken redirect to 0x102:
  - misalign_err = 1, pc holds, imem_req = 0, flush = 1 held.
  - Further redirects and acks have no effect until rst_n pulses low.
- Not-taken redirect, plus wrap-around from pc = 0xFFFF_FFFC with ack:
  - No flush; pc wraps to 0x0000_0000 and misalign_err stays 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter owner and fetch sequencer with redirect flush and misalign halt
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic            redir_valid,
  input  logic            redir_taken,
  input  logic [XLEN-1:0] redir_target,
  output logic            flush,
  output logic [XLEN-1:0] pc,
  output logic            misalign_err
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            outst_q, outst_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            taken;
  logic            aligned;

  assign taken        = redir_valid & redir_taken;
  assign aligned      = (redir_target[1:0] == 2'b00);
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign misalign_err = err_q;

  // State, PC, outstanding-fetch flag, flush counter and sticky error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      outst_q <= 1'b0;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state and output decode; outputs depend only on state, the
  // outstanding flag and stall, never on the redirect inputs
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    outst_d  = outst_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    imem_req = 1'b0;
    flush    = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        // An issued request is held until acked even if stall rises
        imem_req = outst_q | ~stall;
        if (taken) begin
          outst_d = 1'b0;
          if (aligned) begin
            pc_d    = redir_target;
            cnt_d   = FLUSH_LOAD;
            state_d = FLUSH;
          end else begin
            err_d   = 1'b1;
            state_d = HALT;
          end
        end else if (imem_req) begin
          if (imem_ack) begin
            pc_d    = pc_q + XLEN'(4);
            outst_d = 1'b0;
          end else begin
            outst_d = 1'b1;
          end
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (taken) begin
          if (aligned) begin
            // The redirect cycle itself counts as the first cycle of the
            // restarted window, so only FLUSH_CYCLES-1 more cycles follow
            pc_d = redir_target;
            if (FLUSH_LOAD == 4'd1) begin
              cnt_d   = 4'd0;
              state_d = FETCH;
            end else begin
              cnt_d = FLUSH_LOAD - 4'd1;
            end
          end else begin
            err_d   = 1'b1;
            state_d = HALT;
          end
        end else if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HALT: begin
        flush = 1'b1;
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer with a cycle-level reference model
module tb_pc_sequencer;

  localparam int          FC = 2;
  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        imem_ack = 1'b0;
  logic        redir_valid = 1'b0;
  logic        redir_taken = 1'b0;
  logic [31:0] redir_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        flush;
  logic [31:0] pc;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(
    .XLEN(32),
    .RESET_VECTOR(RV),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .redir_valid(redir_valid),
    .redir_taken(redir_taken),
    .redir_target(redir_target),
    .flush(flush),
    .pc(pc),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles since reset release, the cycle at which the
  // current flush window ends, and whether a fetch is pending
  logic [31:0] m_pc = RV;
  int          m_cyc = 0;
  int          m_flush_end = 0;
  bit          m_pend = 1'b0;
  bit          m_halt = 1'b0;
  bit          m_err = 1'b0;

  function automatic bit m_flushing();
    return (m_cyc != 0) && !m_halt && (m_cyc < m_flush_end);
  endfunction

  function automatic bit m_req();
    return (m_cyc != 0) && !m_halt && !m_flushing() && (m_pend || !stall);
  endfunction

  // Advance the model on each rising edge
  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc <= RV; m_cyc <= 0; m_flush_end <= 0;
      m_pend <= 1'b0; m_halt <= 1'b0; m_err <= 1'b0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_cyc != 0 && !m_halt) begin
        if (redir_valid && redir_taken) begin
          if (redir_target[1:0] != 2'b00) begin
            m_halt <= 1'b1;
            m_err  <= 1'b1;
          end else begin
            m_pc        <= redir_target;
            m_pend      <= 1'b0;
            m_flush_end <= m_flushing() ? m_cyc + FC : m_cyc + 1 + FC;
          end
        end else if (m_req()) begin
          if (imem_ack) begin
            m_pc   <= m_pc + 32'd4;
            m_pend <= 1'b0;
          end else begin
            m_pend <= 1'b1;
          end
        end
      end
    end
  end

  // Compare DUT outputs against the model every falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_req", {31'b0, imem_req}, 32'd0);
      check("rst_flush", {31'b0, flush}, 32'd0);
      check("rst_pc", pc, RV);
      check("rst_err", {31'b0, misalign_err}, 32'd0);
    end else begin
      check("m_req", {31'b0, imem_req}, {31'b0, m_req()});
      check("m_flush", {31'b0, flush}, {31'b0, (m_halt || m_flushing())});
      check("m_pc", pc, m_pc);
      check("m_addr", imem_addr, m_pc);
      check("m_err", {31'b0, misalign_err}, {31'b0, m_err});
    end
  end

  task automatic step(input bit s, input bit a, input bit rv, input bit rt, input logic [31:0] tg);
    @(posedge clk);
    #1;
    stall = s; imem_ack = a; redir_valid = rv; redir_taken = rt; redir_target = tg;
    #3;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    stall = 1'b0; imem_ack = 1'b0; redir_valid = 1'b0; redir_taken = 1'b0; redir_target = 32'h0;
    #3;
    check("lit_rst_pc", pc, 32'h0);
    check("lit_rst_err", {31'b0, misalign_err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #3;
    check("lit_boot_req", {31'b0, imem_req}, 32'd0);
  endtask

  initial begin
    // Sequential fetch with ack every cycle
    do_reset();
    step(0, 1, 0, 0, 0); check("lit_s1_req", {31'b0, imem_req}, 32'd1); check("lit_s1_a0", imem_addr, 32'h0);
    step(0, 1, 0, 0, 0); check("lit_s1_a4", imem_addr, 32'h4);
    step(0, 1, 0, 0, 0); check("lit_s1_a8", imem_addr, 32'h8);
    step(0, 1, 0, 0, 0); check("lit_s1_ac", imem_addr, 32'hC);

    // Delayed ack with stall rising during the wait
    do_reset();
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0); check("lit_s2_w0", imem_addr, 32'h4);
    step(1, 0, 0, 0, 0); check("lit_s2_req1", {31'b0, imem_req}, 32'd1);
    step(1, 0, 0, 0, 0); check("lit_s2_w2", imem_addr, 32'h4);
    step(1, 1, 0, 0, 0); check("lit_s2_ackreq", {31'b0, imem_req}, 32'd1);
    step(1, 0, 0, 0, 0); check("lit_s2_a8", imem_addr, 32'h8); check("lit_s2_noreq", {31'b0, imem_req}, 32'd0);
    step(1, 0, 0, 0, 0);

    // Redirect to 0x100 colliding with ack at pc 0x8
    step(0, 1, 1, 1, 32'h100); check("lit_s3_a8", imem_addr, 32'h8);
    step(0, 0, 0, 0, 0); check("lit_s3_pc", pc, 32'h100); check("lit_s3_fl1", {31'b0, flush}, 32'd1);
    step(0, 0, 0, 0, 0); check("lit_s3_fl2", {31'b0, flush}, 32'd1); check("lit_s3_req0", {31'b0, imem_req}, 32'd0);
    step(0, 1, 0, 0, 0); check("lit_s3_fl0", {31'b0, flush}, 32'd0); check("lit_s3_a100", imem_addr, 32'h100);

    // Second redirect on the 2nd flush cycle
    step(0, 0, 1, 1, 32'h180); check("lit_s4_a104", imem_addr, 32'h104);
    step(0, 0, 0, 0, 0); check("lit_s4_fl1", {31'b0, flush}, 32'd1);
    step(0, 0, 1, 1, 32'h200); check("lit_s4_fl2", {31'b0, flush}, 32'd1);
    step(0, 0, 0, 0, 0); check("lit_s4_fl3", {31'b0, flush}, 32'd1); check("lit_s4_pc", pc, 32'h200);
    step(0, 0, 0, 0, 0); check("lit_s4_fl0", {31'b0, flush}, 32'd0); check("lit_s4_a200", imem_addr, 32'h200);

    // Misaligned target halts until reset
    step(0, 1, 1, 1, 32'h102);
    step(0, 1, 1, 1, 32'h300); check("lit_s5_err", {31'b0, misalign_err}, 32'd1); check("lit_s5_pc", pc, 32'h200);
    step(0, 1, 0, 0, 0); check("lit_s5_fl", {31'b0, flush}, 32'd1); check("lit_s5_req", {31'b0, imem_req}, 32'd0);
    do_reset();

    // Not-taken result plus wrap-around
    step(0, 0, 1, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0); check("lit_s6_pc", pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 32'h500); check("lit_s6_req", {31'b0, imem_req}, 32'd1);
    step(0, 0, 0, 0, 0); check("lit_s6_wrap", pc, 32'h0); check("lit_s6_fl", {31'b0, flush}, 32'd0);
    check("lit_s6_err", {31'b0, misalign_err}, 32'd0);

    // Asynchronous reset in the middle of a flush
    step(0, 0, 1, 1, 32'h40);
    step(0, 0, 0, 0, 0); check("lit_s7_fl", {31'b0, flush}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("lit_s7_rfl", {31'b0, flush}, 32'd0);
    check("lit_s7_rpc", pc, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0); check("lit_s7_a4", imem_addr, 32'h4);
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
